// File: rtl/stage_writeback_pkg.sv
// -----------------------------------------------------------------------------
// stage_writeback_pkg
//
// Shared instruction decode for the 16-bit pipeline. Execute, hazard and
// writeback logic import this package so they all agree on which opcodes
// write the register file and which opcodes update the N/Z flags.
//
// Instruction fields:
//   [3:0]  opcode
//   [4]    immediate flag (register vs immediate form of the same opcode)
//   [7:5]  Rx (destination / source A)
//   [10:8] Ry (source B)
// -----------------------------------------------------------------------------
package stage_writeback_pkg;

   localparam int unsigned DataW   = 16;
   localparam int unsigned RegIdxW = 3;
   localparam int unsigned OpW     = 4;

   // Opcode map. The immediate form of an opcode shares the encoding and is
   // distinguished only by ir[4]. Encodings 11..15 are undefined.
   localparam logic [OpW-1:0] OP_MV_X   = 4'd0;
   localparam logic [OpW-1:0] OP_ADD_X  = 4'd1;
   localparam logic [OpW-1:0] OP_SUB_X  = 4'd2;
   localparam logic [OpW-1:0] OP_CMP_X  = 4'd3;
   localparam logic [OpW-1:0] OP_LD     = 4'd4;
   localparam logic [OpW-1:0] OP_ST     = 4'd5;
   localparam logic [OpW-1:0] OP_MVHI   = 4'd6;
   localparam logic [OpW-1:0] OP_J_X    = 4'd7;
   localparam logic [OpW-1:0] OP_JZ_X   = 4'd8;
   localparam logic [OpW-1:0] OP_JN_X   = 4'd9;
   localparam logic [OpW-1:0] OP_CALL_X = 4'd10;

   // Calls deposit their return address here.
   localparam logic [RegIdxW-1:0] WB_LINK_REG = 3'd7;

   // Source of the register-file write data for a retiring instruction.
   typedef enum logic [1:0] {
      WbNone,
      WbAlu,
      WbMem,
      WbLink
   } wb_src_e;

   function automatic wb_src_e op_wb_src(input logic [OpW-1:0] op);
      wb_src_e src;
      case (op)
         OP_MV_X, OP_ADD_X, OP_SUB_X, OP_MVHI: src = WbAlu;
         OP_LD:                                src = WbMem;
         OP_CALL_X:                            src = WbLink;
         default:                              src = WbNone;
      endcase
      return src;
   endfunction

   function automatic logic op_writes_rf(input logic [OpW-1:0] op);
      return op_wb_src(op) != WbNone;
   endfunction

   // Only arithmetic that produces a meaningful comparison result moves the
   // flags; moves and loads leave them alone.
   function automatic logic op_sets_flags(input logic [OpW-1:0] op);
      return (op == OP_ADD_X) || (op == OP_SUB_X) || (op == OP_CMP_X);
   endfunction

endpackage

// File: rtl/fwd_detect.sv
// -----------------------------------------------------------------------------
// fwd_detect
//
// Compares the register being written this cycle against both source fields
// of the instruction in the RF-read stage, so that stage can take the write
// data instead of the stale register-file value.
//
// Ports:
//   rf_we       in   write enable of the retiring instruction
//   rf_sel_w    in   write register index
//   next_ir     in   instruction in the RF-read stage ([7:5] src A, [10:8] src B)
//   detect_reg  out  bit 0: forward onto A, bit 1: forward onto B
// -----------------------------------------------------------------------------
module fwd_detect
   import stage_writeback_pkg::*;
(
   input  logic               rf_we,
   input  logic [RegIdxW-1:0] rf_sel_w,
   input  logic [DataW-1:0]   next_ir,
   output logic [1:0]         detect_reg
);

   logic [RegIdxW-1:0] src_a;
   logic [RegIdxW-1:0] src_b;

   assign src_a = next_ir[7:5];
   assign src_b = next_ir[10:8];

   // No qualification on whether next_ir really reads A or B, and r0 is an
   // ordinary register here; the consumer drops any bit it does not need.
   always_comb begin
      detect_reg    = 2'b00;
      detect_reg[0] = rf_we & (rf_sel_w == src_a);
      detect_reg[1] = rf_we & (rf_sel_w == src_b);
   end

   logic unused_next_ir;
   assign unused_next_ir = ^{next_ir[15:11], next_ir[4:0]};

endmodule

// File: rtl/stage_writeback.sv
// -----------------------------------------------------------------------------
// stage_writeback
//
// Last pipeline stage. Holds the retiring instruction, picks the write data
// (ALU result, load data or return address), drives the register-file write
// port, owns the architectural N/Z flags, counts retired instructions and
// produces the same-cycle forwarding value and hit bits for the RF-read stage.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   valid_in          execute-stage instruction is valid
//   ir_in             execute-stage instruction
//   alu_result_in     execute-stage ALU result
//   alu_n_in/z_in     ALU flags for that result
//   pc_plus2_in       return address for calls
//   mem_rdata         synchronous memory read data (valid while load is here)
//   stall_in          hold the stage, suppress every architectural update
//   flush_in          squash the instruction being captured
//   next_ir           instruction in the RF-read stage
//   valid_out         stage register holds a valid instruction
//   rf_we/sel_w/wdata register-file write port
//   flag_n, flag_z    architectural flags
//   fwd_data          forwarding value (same as rf_wdata)
//   detect_reg        forward hit on source A (bit 0) / source B (bit 1)
//   retired           retired-instruction counter, wraps
// -----------------------------------------------------------------------------
module stage_writeback
   import stage_writeback_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               valid_in,
   input  logic [DataW-1:0]   ir_in,
   input  logic [DataW-1:0]   alu_result_in,
   input  logic               alu_n_in,
   input  logic               alu_z_in,
   input  logic [DataW-1:0]   pc_plus2_in,
   input  logic [DataW-1:0]   mem_rdata,
   input  logic               stall_in,
   input  logic               flush_in,
   input  logic [DataW-1:0]   next_ir,
   output logic               valid_out,
   output logic               rf_we,
   output logic [RegIdxW-1:0] rf_sel_w,
   output logic [DataW-1:0]   rf_wdata,
   output logic               flag_n,
   output logic               flag_z,
   output logic [DataW-1:0]   fwd_data,
   output logic [1:0]         detect_reg,
   output logic [DataW-1:0]   retired
);

   // ---------------------------------------------------------------------
   // Stage register and architectural state
   // ---------------------------------------------------------------------
   logic             valid_q, valid_d;
   logic [DataW-1:0] ir_q,    ir_d;
   logic [DataW-1:0] alu_q,   alu_d;
   logic             n_q,     n_d;
   logic             z_q,     z_d;
   logic [DataW-1:0] pc2_q,   pc2_d;
   logic             flag_n_q, flag_n_d;
   logic             flag_z_q, flag_z_d;
   logic [DataW-1:0] retired_q, retired_d;

   // ---------------------------------------------------------------------
   // Decode of the instruction held in the stage
   // ---------------------------------------------------------------------
   logic [OpW-1:0] op;
   wb_src_e        wb_src;
   logic           retire;

   assign op     = ir_q[3:0];
   assign wb_src = op_wb_src(op);
   // An instruction leaves the stage on any edge where it is valid and the
   // pipe is moving; a stall keeps it here for another try.
   assign retire = valid_q & ~stall_in;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      valid_d   = valid_q;
      ir_d      = ir_q;
      alu_d     = alu_q;
      n_d       = n_q;
      z_d       = z_q;
      pc2_d     = pc2_q;
      flag_n_d  = flag_n_q;
      flag_z_d  = flag_z_q;
      retired_d = retired_q;

      // Stall beats flush: a squash request during a stall is ignored
      // because nothing is being captured.
      if (!stall_in) begin
         valid_d = valid_in & ~flush_in;
         ir_d    = ir_in;
         alu_d   = alu_result_in;
         n_d     = alu_n_in;
         z_d     = alu_z_in;
         pc2_d   = pc_plus2_in;
      end

      if (retire) begin
         retired_d = retired_q + 16'd1;
         if (op_sets_flags(op)) begin
            flag_n_d = n_q;
            flag_z_d = z_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q   <= 1'b0;
         ir_q      <= '0;
         alu_q     <= '0;
         n_q       <= 1'b0;
         z_q       <= 1'b0;
         pc2_q     <= '0;
         flag_n_q  <= 1'b0;
         flag_z_q  <= 1'b0;
         retired_q <= '0;
      end else begin
         valid_q   <= valid_d;
         ir_q      <= ir_d;
         alu_q     <= alu_d;
         n_q       <= n_d;
         z_q       <= z_d;
         pc2_q     <= pc2_d;
         flag_n_q  <= flag_n_d;
         flag_z_q  <= flag_z_d;
         retired_q <= retired_d;
      end
   end

   // ---------------------------------------------------------------------
   // Write port
   // ---------------------------------------------------------------------
   always_comb begin
      rf_we    = retire & (wb_src != WbNone);
      rf_sel_w = (wb_src == WbLink) ? WB_LINK_REG : ir_q[7:5];
      // Non-writing opcodes fall through to alu_q so the bus is quiet (zero)
      // out of reset, when ir_q decodes as MV.
      unique case (wb_src)
         WbMem:   rf_wdata = mem_rdata;
         WbLink:  rf_wdata = pc2_q;
         default: rf_wdata = alu_q;
      endcase
   end

   assign fwd_data  = rf_wdata;
   assign valid_out = valid_q;
   assign flag_n    = flag_n_q;
   assign flag_z    = flag_z_q;
   assign retired   = retired_q;

   // ---------------------------------------------------------------------
   // Forwarding hit detection
   // ---------------------------------------------------------------------
   fwd_detect u_fwd_detect (
      .rf_we      (rf_we),
      .rf_sel_w   (rf_sel_w),
      .next_ir    (next_ir),
      .detect_reg (detect_reg)
   );

   // Upper Ry/immediate bits and the immediate flag do not affect writeback.
   logic unused_ir;
   assign unused_ir = ^{ir_q[15:8], ir_q[4]};

endmodule

// File: tb/tb_stage_writeback.sv
// Directed bench for stage_writeback: each step drives the execute-side
// inputs, advances one clock, and compares outputs against hand-computed
// values one time unit after the rising edge.
module tb_stage_writeback;
   import stage_writeback_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [15:0] ir_in;
   logic [15:0] alu_result_in;
   logic        alu_n_in;
   logic        alu_z_in;
   logic [15:0] pc_plus2_in;
   logic [15:0] mem_rdata;
   logic        stall_in;
   logic        flush_in;
   logic [15:0] next_ir;
   logic        valid_out;
   logic        rf_we;
   logic [2:0]  rf_sel_w;
   logic [15:0] rf_wdata;
   logic        flag_n;
   logic        flag_z;
   logic [15:0] fwd_data;
   logic [1:0]  detect_reg;
   logic [15:0] retired;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   stage_writeback dut (
      .clk           (clk),
      .reset         (reset),
      .valid_in      (valid_in),
      .ir_in         (ir_in),
      .alu_result_in (alu_result_in),
      .alu_n_in      (alu_n_in),
      .alu_z_in      (alu_z_in),
      .pc_plus2_in   (pc_plus2_in),
      .mem_rdata     (mem_rdata),
      .stall_in      (stall_in),
      .flush_in      (flush_in),
      .next_ir       (next_ir),
      .valid_out     (valid_out),
      .rf_we         (rf_we),
      .rf_sel_w      (rf_sel_w),
      .rf_wdata      (rf_wdata),
      .flag_n        (flag_n),
      .flag_z        (flag_z),
      .fwd_data      (fwd_data),
      .detect_reg    (detect_reg),
      .retired       (retired)
   );

   function automatic logic [15:0] mk_ir(input logic [3:0] op, input logic imm,
                                         input logic [2:0] rx, input logic [2:0] ry);
      return {5'd0, ry, rx, imm, op};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; valid_in = 1'b0; ir_in = '0; alu_result_in = '0;
      alu_n_in = 1'b0; alu_z_in = 1'b0; pc_plus2_in = '0; mem_rdata = '0;
      stall_in = 1'b0; flush_in = 1'b0; next_ir = '0;
      tick(); tick();
      reset = 1'b0;
      tick();

      // Reset / idle
      chk("rst_valid",   {15'd0, valid_out}, 16'd0);
      chk("rst_we",      {15'd0, rf_we}, 16'd0);
      chk("rst_detect",  {14'd0, detect_reg}, 16'd0);
      chk("rst_flag_n",  {15'd0, flag_n}, 16'd0);
      chk("rst_flag_z",  {15'd0, flag_z}, 16'd0);
      chk("rst_retired", retired, 16'd0);
      chk("rst_wdata",   rf_wdata, 16'd0);

      // ADD r3 <- 8000, N=1; forwards onto both A=3 and B=3
      valid_in = 1'b1; ir_in = mk_ir(OP_ADD_X, 1'b0, 3'd3, 3'd1);
      alu_result_in = 16'h8000; alu_n_in = 1'b1; alu_z_in = 1'b0;
      tick();
      valid_in = 1'b0; ir_in = '0; next_ir = 16'h0360;
      #1;
      chk("add_we",      {15'd0, rf_we}, 16'd1);
      chk("add_sel",     {13'd0, rf_sel_w}, 16'd3);
      chk("add_fwd",     fwd_data, 16'h8000);
      chk("add_wdata",   rf_wdata, 16'h8000);
      chk("add_detect",  {14'd0, detect_reg}, 16'd3);
      chk("add_n_pre",   {15'd0, flag_n}, 16'd0);
      tick();
      chk("add_flag_n",  {15'd0, flag_n}, 16'd1);
      chk("add_flag_z",  {15'd0, flag_z}, 16'd0);
      chk("add_retired", retired, 16'd1);
      chk("bubble_we",   {15'd0, rf_we}, 16'd0);

      // LD r2 with N/Z presented as 0/1, which must not reach the flags
      valid_in = 1'b1; ir_in = mk_ir(OP_LD, 1'b0, 3'd2, 3'd0);
      alu_result_in = 16'hFFFF; alu_n_in = 1'b0; alu_z_in = 1'b1;
      tick();
      valid_in = 1'b0; mem_rdata = 16'h1234; next_ir = 16'h02A0;
      #1;
      chk("ld_wdata",    rf_wdata, 16'h1234);
      chk("ld_sel",      {13'd0, rf_sel_w}, 16'd2);
      chk("ld_we",       {15'd0, rf_we}, 16'd1);
      chk("ld_detect",   {14'd0, detect_reg}, 16'd2);
      tick();
      chk("ld_flag_n",   {15'd0, flag_n}, 16'd1);
      chk("ld_flag_z",   {15'd0, flag_z}, 16'd0);
      chk("ld_retired",  retired, 16'd2);

      // CALL (immediate form, Rx=3 ignored) then CMP with Z=1
      valid_in = 1'b1; ir_in = mk_ir(OP_CALL_X, 1'b1, 3'd3, 3'd0);
      alu_result_in = 16'h5555; pc_plus2_in = 16'h0042;
      alu_n_in = 1'b0; alu_z_in = 1'b0;
      tick();
      ir_in = mk_ir(OP_CMP_X, 1'b1, 3'd7, 3'd0);
      alu_result_in = 16'h0000; alu_n_in = 1'b0; alu_z_in = 1'b1;
      next_ir = 16'h00E0;
      #1;
      chk("call_sel",    {13'd0, rf_sel_w}, 16'd7);
      chk("call_wdata",  rf_wdata, 16'h0042);
      chk("call_we",     {15'd0, rf_we}, 16'd1);
      chk("call_detect", {14'd0, detect_reg}, 16'd1);
      tick();
      valid_in = 1'b0;
      #1;
      chk("cmp_we",      {15'd0, rf_we}, 16'd0);
      chk("cmp_detect",  {14'd0, detect_reg}, 16'd0);
      chk("cmp_z_pre",   {15'd0, flag_z}, 16'd0);
      chk("cmp_ret_pre", retired, 16'd3);
      tick();
      chk("cmp_flag_z",  {15'd0, flag_z}, 16'd1);
      chk("cmp_flag_n",  {15'd0, flag_n}, 16'd0);
      chk("cmp_retired", retired, 16'd4);

      // MV r1 held for three stall cycles; an ADD waiting behind must not load
      valid_in = 1'b1; ir_in = mk_ir(OP_MV_X, 1'b0, 3'd1, 3'd0);
      alu_result_in = 16'h00AB;
      tick();
      stall_in = 1'b1; ir_in = mk_ir(OP_ADD_X, 1'b0, 3'd4, 3'd0);
      alu_result_in = 16'h7777; alu_n_in = 1'b1; alu_z_in = 1'b0;
      next_ir = 16'h0020;
      #1;
      chk("stall1_we",   {15'd0, rf_we}, 16'd0);
      chk("stall1_det",  {14'd0, detect_reg}, 16'd0);
      tick();
      chk("stall2_we",   {15'd0, rf_we}, 16'd0);
      chk("stall2_ret",  retired, 16'd4);
      tick();
      chk("stall3_we",   {15'd0, rf_we}, 16'd0);
      chk("stall3_val",  {15'd0, valid_out}, 16'd1);
      chk("stall3_ret",  retired, 16'd4);
      stall_in = 1'b0; valid_in = 1'b0;
      #1;
      chk("rel_we",      {15'd0, rf_we}, 16'd1);
      chk("rel_sel",     {13'd0, rf_sel_w}, 16'd1);
      chk("rel_wdata",   rf_wdata, 16'h00AB);
      chk("rel_detect",  {14'd0, detect_reg}, 16'd1);
      tick();
      chk("rel_we_once", {15'd0, rf_we}, 16'd0);
      chk("rel_retired", retired, 16'd5);
      chk("rel_flag_n",  {15'd0, flag_n}, 16'd0);

      // Flush squashes an incoming MV r5
      valid_in = 1'b1; flush_in = 1'b1; ir_in = mk_ir(OP_MV_X, 1'b0, 3'd5, 3'd0);
      alu_result_in = 16'h0BAD;
      tick();
      valid_in = 1'b0; flush_in = 1'b0; next_ir = 16'h00A0;
      #1;
      chk("fl_valid",    {15'd0, valid_out}, 16'd0);
      chk("fl_we",       {15'd0, rf_we}, 16'd0);
      chk("fl_detect",   {14'd0, detect_reg}, 16'd0);
      tick();
      chk("fl_retired",  retired, 16'd5);

      // Undefined opcode: retires, no write, flags untouched
      valid_in = 1'b1; ir_in = mk_ir(4'hF, 1'b0, 3'd2, 3'd0);
      alu_n_in = 1'b1; alu_z_in = 1'b0; next_ir = 16'h0040;
      tick();
      valid_in = 1'b0;
      #1;
      chk("und_we",      {15'd0, rf_we}, 16'd0);
      chk("und_detect",  {14'd0, detect_reg}, 16'd0);
      tick();
      chk("und_retired", retired, 16'd6);
      chk("und_flag_n",  {15'd0, flag_n}, 16'd0);
      chk("und_flag_z",  {15'd0, flag_z}, 16'd1);

      // Reset during a stall discards the held MV r6
      valid_in = 1'b1; ir_in = mk_ir(OP_MV_X, 1'b0, 3'd6, 3'd0);
      alu_result_in = 16'h00C6;
      tick();
      valid_in = 1'b0; stall_in = 1'b1; reset = 1'b1;
      tick();
      reset = 1'b0; stall_in = 1'b0;
      #1;
      chk("rs_valid",    {15'd0, valid_out}, 16'd0);
      chk("rs_we",       {15'd0, rf_we}, 16'd0);
      chk("rs_retired",  retired, 16'd0);
      chk("rs_flag_z",   {15'd0, flag_z}, 16'd0);
      chk("rs_wdata",    rf_wdata, 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stage_writeback.md
# stage_writeback

Final stage of the 16-bit pipelined CPU, and the write side of the register-file read/decode stage. It holds the retiring instruction in a pipeline register and selects write data (ALU result, load data or return address). It drives the register-file write port and owns the architectural N/Z flags. It also produces the same-cycle forwarding value and the `detect_reg` bits consumed by the RF-read stage.

## Interface
- No parameters. Data width is 16 bits, register index is 3 bits, 8 registers; r7 is the link register.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `valid_in` in 1: the instruction from the execute stage is valid.
- `ir_in` in 16: execute-stage instruction. Opcode is `[3:0]`, immediate flag is `[4]`, Rx is `[7:5]`.
- `alu_result_in` in 16: execute-stage ALU result.
- `alu_n_in`, `alu_z_in` in 1 each: ALU negative and zero flags for this result.
- `pc_plus2_in` in 16: address following the instruction, used as the call return address.
- `mem_rdata` in 16: synchronous data-memory read data, valid in the cycle after the load leaves execute.
- `stall_in` in 1: hold the stage and suppress all architectural updates.
- `flush_in` in 1: squash the instruction being captured this cycle.
- `next_ir` in 16: instruction currently in the RF-read stage. Its `[7:5]` is source A and `[10:8]` is source B.
- `valid_out` out 1: the stage register holds a valid instruction.
- `rf_we` out 1: register-file write enable.
- `rf_sel_w` out 3: write register index.
- `rf_wdata` out 16: write data.
- `flag_n`, `flag_z` out 1 each: architectural flags.
- `fwd_data` out 16: forwarding value, always equal to `rf_wdata`.
- `detect_reg` out 2: bit 0 forwards onto source A, bit 1 forwards onto source B.
- `retired` out 16: count of retired instructions.

## Operation
Stage register:
- Fields: `valid_q`, `ir_q`, `alu_q`, `n_q`, `z_q`, `pc2_q`.
- When `stall_in` is 0, all fields load from the inputs, and `valid_q` loads `valid_in & ~flush_in`.
- When `stall_in` is 1, all fields hold.

Write classification, decoded from `ir_q[3:0]` using the `op.svh` constants:
- MV, ADD, SUB, MVHI: write Rx with `alu_q`.
- LD: write Rx with `mem_rdata`.
- CALL (register or immediate form): write r7 with `pc2_q`.
- CMP, ST and J/JZ/JN: no register write.
- Undefined opcodes: no write, no flag update. They still retire.

Write port and counter:
- `rf_we` = `valid_q & writes(ir_q) & ~stall_in`.
- `rf_sel_w` = 7 for CALL, otherwise `ir_q[7:5]`.
- `rf_wdata` follows the mux above.
- `retired` increments when `valid_q & ~stall_in`. It wraps at 16'hFFFF to 0.

Flags:
- On the clock edge, when `valid_q & ~stall_in` and the opcode is ADD, SUB or CMP (either immediate form), `flag_n <= n_q` and `flag_z <= z_q`.
- In all other cycles the flags hold.

Forwarding:
- `detect_reg[0]` = `rf_we & (rf_sel_w == next_ir[7:5])`.
- `detect_reg[1]` = `rf_we & (rf_sel_w == next_ir[10:8])`.
- Both bits may be set together.
- Register index 0 gets no special treatment.
- `next_ir` is compared even when it encodes no register read. The RF-read stage ignores any bit it does not use.

## Timing
Reset values:
- `valid_q` = 0, `ir_q` = 0, `alu_q` = 0, `pc2_q` = 0.
- `flag_n` = 0, `flag_z` = 0, `retired` = 0.
- Consequently `valid_out` = 0, `rf_we` = 0, `detect_reg` = 0, `rf_wdata` = `fwd_data` = 0.
- `reset` takes priority over `stall_in` and `flush_in`.
- Reset asserted mid-stall discards the held instruction with no write.

Cycle behaviour:
- Latency is one cycle from execute to the write. `rf_we` and `rf_wdata` are combinational from the stage register, and the register file commits them on the next edge.
- `detect_reg` and `fwd_data` are combinational in the same cycle, so the RF-read stage sees write-before-read with no bubble.
- Load data: `mem_rdata` is sampled combinationally during the cycle in which the load occupies this stage.
- During a stall the memory holds its read data. Neither `rf_we` nor `detect_reg` asserts during a stall, so a held instruction writes exactly once, in the first cycle after the stall releases.

Simultaneous events:
- `stall_in` with `flush_in`: the stall wins and the stage register holds.
- `flush_in` alone: the instruction in the stage still retires. Only the incoming instruction is squashed.

## Structure
- Opcode constants (`OP_MV_X` … `OP_CALL_X`, `OP_LD`, `OP_ST`, `OP_MVHI`) come from the shared `op.svh`.
- Add to `op.svh`: a `WB_LINK_REG` constant (3'd7), and the helper functions `op_writes_rf` and `op_sets_flags`, so that execute and hazard logic share one decode.
- One sub-module, `fwd_detect`: inputs `rf_we`, `rf_sel_w` and `next_ir`; output `detect_reg[1:0]`.

## Test plan
- Reset, then idle: `rf_we`=0, `detect_reg`=0, `flag_n`=`flag_z`=0, `retired`=0.
- ADD r3, `alu_result_in`=16'h8000, n=1, z=0, then `next_ir` with A=3 and B=3. Next cycle: `rf_we`=1, `rf_sel_w`=3, `fwd_data`=16'h8000, `detect_reg`=2'b11. Following cycle: `flag_n`=1, `retired`=1.
- LD r2 with `mem_rdata`=16'h1234 in the stage cycle: `rf_wdata`=16'h1234, `rf_sel_w`=2. Flags unchanged.
- CALL with `pc_plus2_in`=16'h0042: `rf_sel_w`=7, `rf_wdata`=16'h0042. A CMP with z=1 that follows: `rf_we`=0, then `flag_z`=1.
- MV r1 held by a 3-cycle `stall_in`: `rf_we`=0 for all 3 cycles, exactly one write after release, `retired` increments by 1.
- `flush_in` together with a valid MV r5: the instruction never writes and `retired` is unchanged.
